// File: rtl/change_dispenser.sv
// change_dispenser: greedy one-coin-at-a-time change payout to a ready-handshaked coin hopper.
// Define CHG_QUARTER_EN to enable the quarter hopper; otherwise only dimes and nickels are paid.
module change_dispenser #(
  parameter int CHANGE_W  = 5,
  parameter int PULSE_GAP = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                soda_i,
  input  logic [CHANGE_W-1:0] change_i,
  input  logic                hopper_ready_i,
  output logic                eject_quarter_o,
  output logic                eject_dime_o,
  output logic                eject_nickle_o,
  output logic [CHANGE_W-1:0] remaining_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                residue_err_o,
  output logic                overrun_o
);
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;
  typedef enum logic [1:0] {C_N, C_D, C_Q} coin_t;
  localparam int GW = $clog2(PULSE_GAP) + 1;
  localparam logic [CHANGE_W-1:0] V25 = CHANGE_W'(25);
  localparam logic [CHANGE_W-1:0] V10 = CHANGE_W'(10);
  localparam logic [CHANGE_W-1:0] V5  = CHANGE_W'(5);
`ifdef CHG_QUARTER_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  state_t state, next;
  coin_t coin, coin_d;
  logic [CHANGE_W-1:0] rem, rem_d, pend, pend_d, coin_val;
  logic [GW-1:0] gap_cnt;
  logic pend_v, pend_v_d, fire, load_new, store, done_d, res_d, ovr_d, busy_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = soda_i ? SELECT : IDLE;
      SELECT:  next = rem < V5 ? DONE : EJECT;
      EJECT:   next = hopper_ready_i ? GAP : EJECT;
      GAP:     next = gap_cnt == GW'(PULSE_GAP - 1) ? SELECT : GAP;
      DONE:    next = (pend_v || soda_i) ? SELECT : IDLE;
      default: next = IDLE;
    endcase
  end
  // A request arriving in DONE with the slot empty is served straight after this one.
  always_comb begin
    coin_d   = state == SELECT ? (QEN && rem >= V25 ? C_Q : rem >= V10 ? C_D : C_N) : coin;
    coin_val = coin == C_Q ? V25 : coin == C_D ? V10 : V5;
    fire     = state == EJECT && hopper_ready_i;
    load_new = soda_i && (state == IDLE || (state == DONE && !pend_v));
    store    = soda_i && !pend_v && state != IDLE && state != DONE;
    ovr_d    = soda_i && pend_v;
    pend_v_d = store || (pend_v && state != DONE);
    pend_d   = store ? change_i : pend;
    rem_d    = load_new ? change_i :
               (state == DONE && pend_v) ? pend :
               fire ? rem - coin_val :
               (state == SELECT && rem < V5) ? '0 : rem;
    done_d   = next == DONE;
    res_d    = state == SELECT && rem != '0 && rem < V5;
    busy_d   = next != IDLE || pend_v_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      coin           <= C_N;
      rem            <= '0;
      pend           <= '0;
      pend_v         <= 1'b0;
      gap_cnt        <= '0;
      eject_dime_o   <= 1'b0;
      eject_nickle_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      residue_err_o  <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      coin           <= coin_d;
      rem            <= rem_d;
      pend           <= pend_d;
      pend_v         <= pend_v_d;
      gap_cnt        <= state == GAP ? gap_cnt + GW'(1) : '0;
      eject_dime_o   <= fire && coin == C_D;
      eject_nickle_o <= fire && coin == C_N;
      busy_o         <= busy_d;
      done_o         <= done_d;
      residue_err_o  <= res_d;
      overrun_o      <= ovr_d;
    end
`ifdef CHG_QUARTER_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) eject_quarter_o <= 1'b0;
    else eject_quarter_o <= fire && coin == C_Q;
`else
  assign eject_quarter_o = 1'b0;
`endif
  assign remaining_o = rem;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized checks of change_dispenser against a coin-count model.
module tb_change_dispenser;
  localparam int W = 5, PG = 2;
`ifdef CHG_QUARTER_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, soda = 0, ready = 1;
  logic [W-1:0] change = '0;
  logic ej_q, ej_d, ej_n, busy, done, res_err, overrun;
  logic [W-1:0] remaining;
  change_dispenser #(.CHANGE_W(W), .PULSE_GAP(PG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .soda_i(soda), .change_i(change), .hopper_ready_i(ready),
    .eject_quarter_o(ej_q), .eject_dime_o(ej_d), .eject_nickle_o(ej_n), .remaining_o(remaining),
    .busy_o(busy), .done_o(done), .residue_err_o(res_err), .overrun_o(overrun));
  always #5 clk = ~clk;
  int n_checks = 0, n_errors = 0, cyc = 0;
  int exp_coins[$], req_q[$];
  int exp_rem = 0, ej_cnt = 0, done_cnt = 0, ov_cnt = 0, res_cnt = 0;
  int last_ej = -1, last_done = -1, last_ov = -1, first_ej = -1;
  bit exp_res = 0, active = 0;
  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // Coin counts come straight from division: quarters, then dimes, then nickels.
  function automatic void load(int c);
    int q, d, n, r;
    q = QEN ? c / 25 : 0;
    r = c - 25 * q;
    d = r / 10;
    r = r - 10 * d;
    n = r / 5;
    r = r - 5 * n;
    exp_coins.delete();
    repeat (q) exp_coins.push_back(25);
    repeat (d) exp_coins.push_back(10);
    repeat (n) exp_coins.push_back(5);
    exp_rem  = c;
    exp_res  = r != 0;
    active   = 1;
    first_ej = -1;
  endfunction
  task automatic observe();
    int v;
    v = ej_q ? 25 : ej_d ? 10 : ej_n ? 5 : 0;
    if (v != 0) begin
      check("onehot", $countones({ej_q, ej_d, ej_n}), 1);
      check("coin", v, exp_coins.size() != 0 ? exp_coins[0] : 0);
      if (exp_coins.size() != 0) void'(exp_coins.pop_front());
      exp_rem -= v;
      check("remaining", int'(remaining), exp_rem);
      if (last_ej >= 0) check("gap", int'(cyc - last_ej - 1 >= PG), 1);
      if (first_ej < 0) first_ej = cyc;
      last_ej = cyc;
      ej_cnt++;
    end
    if (res_err) res_cnt++;
    if (res_err && !done) check("residue_without_done", 1, 0);
    if (done) begin
      check("done_coins_left", exp_coins.size(), 0);
      check("residue", int'(res_err), int'(exp_res));
      check("rem_at_done", int'(remaining), 0);
      done_cnt++;
      last_done = cyc;
      active = 0;
      if (req_q.size() != 0) load(req_q.pop_front());
    end
    if (overrun) begin
      ov_cnt++;
      last_ov = cyc;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst_n) observe();
  endtask
  task automatic send(int c, bit accepted, output int at);
    soda = 1;
    change = W'(c);
    at = cyc;
    if (accepted) begin
      if (!active) load(c);
      else req_q.push_back(c);
    end
    tick();
    soda = 0;
    change = W'($urandom);
  endtask
  task automatic wait_done(int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    check("idle_reached", int'(busy), 0);
  endtask
  initial begin
    int t, t3, e0, d0, r0, c;
    repeat (3) tick();
    check("reset_outputs", int'({ej_q, ej_d, ej_n, remaining, busy, done, res_err, overrun}), 0);
    rst_n = 1;
    tick();
    send(0, 1, t);
    wait_done(20);
    check("t1_done_latency", last_done - t, 2);
    check("t1_no_eject", ej_cnt, 0);
    wait_idle();
    e0 = ej_cnt;
    send(5, 1, t);
    check("t2_busy", int'(busy), 1);
    check("t2_rem_loaded", int'(remaining), 5);
    wait_done(40);
    check("t2_eject_latency", first_ej - t, 3);
    check("t2_done_latency", last_done - t, 4 + PG);
    check("t2_eject_count", ej_cnt - e0, 1);
    wait_idle();
    e0 = ej_cnt;
    send(30, 1, t);
    wait_done(60);
    check("t3_eject_count", ej_cnt - e0, QEN ? 2 : 3);
    wait_idle();
    ready = 0;
    e0 = ej_cnt;
    send(20, 1, t);
    repeat (12) tick();
    check("t4_no_eject_while_low", ej_cnt - e0, 0);
    ready = 1;
    wait_done(60);
    check("t4_eject_count", ej_cnt - e0, 2);
    wait_idle();
    r0 = res_cnt;
    send(7, 1, t);
    wait_done(40);
    check("t5_residue_pulse", res_cnt - r0, 1);
    tick();
    check("t5_rem_zero", int'(remaining), 0);
    wait_idle();
    d0 = done_cnt;
    send(15, 1, t);
    send(10, 1, t);
    send(25, 0, t3);
    check("t6_overrun_latency", last_ov - t3, 1);
    check("t6_busy_pending", int'(busy), 1);
    wait_done(80);
    wait_done(80);
    check("t6_done_count", done_cnt - d0, 2);
    check("t6_overrun_count", ov_cnt, 1);
    wait_idle();
    ready = 0;
    send(25, 1, t);
    repeat (4) tick();
    #2 rst_n = 0;
    #1 check("rst_async_outputs", int'({ej_q, ej_d, ej_n, remaining, busy, done, res_err, overrun}), 0);
    exp_coins.delete();
    req_q.delete();
    active = 0;
    last_ej = -1;
    ready = 1;
    repeat (2) tick();
    rst_n = 1;
    e0 = ej_cnt;
    repeat (20) tick();
    check("rst_no_late_eject", ej_cnt - e0, 0);
    check("rst_idle", int'(busy), 0);
    for (int k = 0; k < 40; k++) begin
      wait_idle();
      c = int'($urandom_range(0, 31));
      send(c, 1, t);
      check("rand_rem_loaded", int'(remaining), c);
      d0 = done_cnt;
      for (int i = 0; i < 400 && done_cnt == d0; i++) begin
        ready = $urandom_range(0, 3) != 0;
        tick();
      end
      if (done_cnt == d0) check("rand_done_timeout", 0, 1);
      ready = 1;
    end
    check("overrun_total", ov_cnt, 1);
    check("coins_leftover", exp_coins.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
